// File: rtl/iec_pkg.sv
// Shared IEC bus constants: line indices and open-collector level encoding.
package iec_pkg;
    localparam int IEC_ATN   = 0;
    localparam int IEC_CLK   = 1;
    localparam int IEC_DATA  = 2;
    localparam int IEC_LINES = 3;

    localparam logic IEC_REL  = 1'b1;
    localparam logic IEC_PULL = 1'b0;
endpackage

// File: rtl/iec_line_filter.sv
// One IEC bus line: multi-flop synchroniser followed by a stable-count glitch filter.
module iec_line_filter
    import iec_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int FILT_LEN    = 4
) (
    input  logic clk32,
    input  logic reset_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CW-1:0]          cnt;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IEC_REL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // The level moves on the FILT_LEN-th consecutive cycle that disagrees with it.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            dout <= IEC_REL;
        end else if (sync_out == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
            cnt  <= '0;
            dout <= sync_out;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/iec_multi_drive_bus.sv
// IEC serial-bus junction: wired-AND resolution with ATN-acknowledge, filtered lines to
// the drives, shared phi2 enables and a per-drive bus-hold watchdog.
module iec_multi_drive_bus
    import iec_pkg::*;
#(
    parameter int NUM_DRV     = 4,
    parameter int SYNC_STAGES = 3,
    parameter int FILT_LEN    = 4,
    parameter int CLK_DIV     = 32,
    parameter int WDOG_W      = 20
) (
    input  logic               clk32,
    input  logic               reset_n,
    input  logic               host_atn,
    input  logic               host_clk,
    input  logic               host_data,
    input  logic [NUM_DRV-1:0] drv_en,
    input  logic [NUM_DRV-1:0] drv_clk_pull,
    input  logic [NUM_DRV-1:0] drv_data_pull,
    input  logic [NUM_DRV-1:0] drv_atna,
    input  logic               wdog_release,
    input  logic [NUM_DRV-1:0] stuck_clr,
    output logic               bus_clk_raw,
    output logic               bus_data_raw,
    output logic               bus_atn,
    output logic               bus_clk,
    output logic               bus_data,
    output logic               atn_fall,
    output logic               ph2_r,
    output logic               ph2_f,
    output logic [NUM_DRV-1:0] stuck
);
    localparam int PW = $clog2(CLK_DIV);

    logic [NUM_DRV-1:0]   act;
    logic [NUM_DRV-1:0]   ack;
    logic [IEC_LINES-1:0] line_raw;
    logic [IEC_LINES-1:0] line_filt;
    logic                 atn_q;
    logic [PW-1:0]        ph_cnt;

    // ACK pulls DATA whenever the drive's ATNA bit disagrees with the live ATN state.
    always_comb begin
        act = drv_en & ~({NUM_DRV{wdog_release}} & stuck);
        ack = act & (drv_atna ^ {NUM_DRV{~host_atn}});
    end

    assign bus_data_raw = host_data & ~|(act & (drv_data_pull | ack));
    assign bus_clk_raw  = host_clk & ~|(act & drv_clk_pull);

    always_comb begin
        line_raw           = '1;
        line_raw[IEC_ATN]  = host_atn;
        line_raw[IEC_CLK]  = bus_clk_raw;
        line_raw[IEC_DATA] = bus_data_raw;
    end

    for (genvar l = 0; l < IEC_LINES; l++) begin : g_line
        iec_line_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN)
        ) u_filt (
            .clk32  (clk32),
            .reset_n(reset_n),
            .din    (line_raw[l]),
            .dout   (line_filt[l])
        );
    end

    assign bus_atn  = line_filt[IEC_ATN];
    assign bus_clk  = line_filt[IEC_CLK];
    assign bus_data = line_filt[IEC_DATA];

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) atn_q <= IEC_REL;
        else          atn_q <= bus_atn;
    end

    assign atn_fall = (atn_q == IEC_REL) && (bus_atn == IEC_PULL);

    // Starting at the top of the period makes ph2_r the first event after reset.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n)                         ph_cnt <= PW'(CLK_DIV - 1);
        else if (ph_cnt == PW'(CLK_DIV - 1))  ph_cnt <= '0;
        else                                  ph_cnt <= ph_cnt + PW'(1);
    end

    assign ph2_r = (ph_cnt == '0);
    assign ph2_f = (ph_cnt == PW'(CLK_DIV / 2));

    for (genvar i = 0; i < NUM_DRV; i++) begin : g_wdog
        logic [WDOG_W-1:0] cnt;
        logic [WDOG_W-1:0] cnt_inc;
        logic [1:0]        pulls;
        logic [1:0]        prev;
        logic              stuck_q;

        assign pulls   = {drv_clk_pull[i], drv_data_pull[i]};
        assign cnt_inc = cnt + WDOG_W'(1);

        always_ff @(posedge clk32 or negedge reset_n) begin
            if (!reset_n) begin
                prev <= 2'b00;
            end else if (ph2_f) begin
                prev <= pulls;
            end
        end

        // Only an unchanging, non-idle pull pattern accumulates; clear beats a same-cycle set.
        always_ff @(posedge clk32 or negedge reset_n) begin
            if (!reset_n) begin
                cnt     <= '0;
                stuck_q <= 1'b0;
            end else if (stuck_clr[i]) begin
                cnt     <= '0;
                stuck_q <= 1'b0;
            end else if (ph2_f) begin
                if (!drv_en[i] || pulls == 2'b00 || pulls != prev) begin
                    cnt <= '0;
                end else if (cnt != '1) begin
                    cnt <= cnt_inc;
                    if (cnt_inc == '1) stuck_q <= 1'b1;
                end
            end
        end

        assign stuck[i] = stuck_q;
    end
endmodule
